// File: rtl/core_pkg.sv
// core_pkg: shared writeback-select, load-format encodings and default widths
package core_pkg;
  localparam int WORD_SIZE_DEFAULT = 32;
  localparam int REG_SIZE_DEFAULT = 5;
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;
  localparam logic [1:0] WB_SEL_IMM = 2'b11;
  localparam logic [2:0] MEM_SIZE_LB = 3'b000;
  localparam logic [2:0] MEM_SIZE_LH = 3'b001;
  localparam logic [2:0] MEM_SIZE_LW = 3'b010;
  localparam logic [2:0] MEM_SIZE_LBU = 3'b100;
  localparam logic [2:0] MEM_SIZE_LHU = 3'b101;
endpackage

// File: rtl/load_align.sv
// load_align: picks the byte/half/word lane of a load and sign- or zero-extends it
module load_align
  import core_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEFAULT
) (
  input  logic [WORD_SIZE-1:0] read_data,
  input  logic [1:0]           off,
  input  logic [2:0]           mem_size,
  output logic [WORD_SIZE-1:0] data,
  output logic                 misalign
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] w;
  // lane select, extension and alignment check; unknown sizes yield zero
  always_comb begin
    b = read_data[{off, 3'b000} +: 8];
    h = read_data[{off[1], 4'b0000} +: 16];
    w = read_data[31:0];
    data = mem_size == MEM_SIZE_LB  ? WORD_SIZE'($signed(b)) :
           mem_size == MEM_SIZE_LH  ? WORD_SIZE'($signed(h)) :
           mem_size == MEM_SIZE_LW  ? WORD_SIZE'($signed(w)) :
           mem_size == MEM_SIZE_LBU ? WORD_SIZE'(b) :
           mem_size == MEM_SIZE_LHU ? WORD_SIZE'(h) : '0;
    misalign = ((mem_size == MEM_SIZE_LH || mem_size == MEM_SIZE_LHU) && off[0]) ||
               (mem_size == MEM_SIZE_LW && off != 2'b00);
  end
endmodule

// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: registered writeback stage with result mux, load formatting, stall and flush
module wb_stage_pipe
  import core_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEFAULT,
  parameter int REG_SIZE  = REG_SIZE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 reg_write,
  input  logic [1:0]           wb_sel,
  input  logic [2:0]           mem_size,
  input  logic [WORD_SIZE-1:0] alu_result,
  input  logic [WORD_SIZE-1:0] read_data,
  input  logic [WORD_SIZE-1:0] pc_plus4,
  input  logic [WORD_SIZE-1:0] imm,
  input  logic [REG_SIZE-1:0]  dest_reg,
  output logic                 wb_valid,
  output logic                 wb_we,
  output logic [REG_SIZE-1:0]  wb_rd,
  output logic [WORD_SIZE-1:0] wb_data,
  output logic                 misalign_err
);
  logic [WORD_SIZE-1:0] load_data, sel_data, data_d, data_q;
  logic [REG_SIZE-1:0]  rd_d, rd_q;
  logic load_mis, mis, cap;
  logic valid_d, valid_q, we_d, we_q, err_d, err_q;

  load_align #(.WORD_SIZE(WORD_SIZE)) u_align (
    .read_data(read_data),
    .off      (alu_result[1:0]),
    .mem_size (mem_size),
    .data     (load_data),
    .misalign (load_mis)
  );

  assign in_ready = !stall;

  // next-state: flush kills the slot, stall holds it, otherwise capture the new payload
  always_comb begin
    sel_data = wb_sel == WB_SEL_ALU ? alu_result :
               wb_sel == WB_SEL_MEM ? load_data :
               wb_sel == WB_SEL_PC4 ? pc_plus4 : imm;
    mis = in_valid && wb_sel == WB_SEL_MEM && load_mis;
    cap = in_ready && !flush;
    valid_d = flush ? 1'b0 : cap ? in_valid : valid_q;
    we_d = flush ? 1'b0 : cap ? (in_valid && reg_write && dest_reg != '0 && !mis) : we_q;
    err_d = flush ? 1'b0 : cap ? mis : err_q;
    rd_d = cap ? dest_reg : rd_q;
    data_d = cap ? sel_data : data_q;
  end

  // pipeline register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      rd_q <= '0;
      data_q <= '0;
    end else begin
      valid_q <= valid_d;
      we_q <= we_d;
      err_q <= err_d;
      rd_q <= rd_d;
      data_q <= data_d;
    end
  end

  assign wb_valid = valid_q;
  assign wb_we = we_q;
  assign wb_rd = rd_q;
  assign wb_data = data_q;
  assign misalign_err = err_q;
endmodule

// File: tb/tb_wb_stage_pipe.sv
// tb_wb_stage_pipe: directed checks of capture, load formatting, stall/flush, x0 and async reset
module tb_wb_stage_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0, reg_write = 1'b0;
  logic        in_ready, wb_valid, wb_we, misalign_err;
  logic [1:0]  wb_sel = 2'b00;
  logic [2:0]  mem_size = 3'b000;
  logic [31:0] alu_result = '0, read_data = '0, pc_plus4 = '0, imm = '0, wb_data;
  logic [4:0]  dest_reg = '0, wb_rd;
  int checks = 0;
  int errors = 0;

  wb_stage_pipe #(.WORD_SIZE(32), .REG_SIZE(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .flush(flush), .reg_write(reg_write), .wb_sel(wb_sel),
    .mem_size(mem_size), .alu_result(alu_result), .read_data(read_data),
    .pc_plus4(pc_plus4), .imm(imm), .dest_reg(dest_reg), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] sel,
                       input logic [2:0] ms, input logic [31:0] alu,
                       input logic [31:0] rdat, input logic [4:0] rd);
    in_valid = v; reg_write = rw; wb_sel = sel; mem_size = ms;
    alu_result = alu; read_data = rdat; dest_reg = rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", wb_valid); end
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", wb_we); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", wb_rd); end
    checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", wb_data); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", misalign_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_capture();
    drive(1, 1, 2'b00, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
    tick();
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL cap_valid got=%b exp=1", wb_valid); end
    checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL cap_we got=%b exp=1", wb_we); end
    checks++; if (wb_rd !== 5'd5) begin errors++; $display("FAIL cap_rd got=%0d exp=5", wb_rd); end
    checks++; if (wb_data !== 32'h0000_1234) begin errors++; $display("FAIL cap_data got=%h exp=00001234", wb_data); end
  endtask

  task automatic test_byte_load();
    drive(1, 1, 2'b01, 3'b000, 32'd3, 32'h80FF_7F01, 5'd4);
    tick();
    checks++; if (wb_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb3_data got=%h exp=ffffff80", wb_data); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL lb3_err got=%b exp=0", misalign_err); end
    drive(1, 1, 2'b01, 3'b100, 32'd3, 32'h80FF_7F01, 5'd4);
    tick();
    checks++; if (wb_data !== 32'h0000_0080) begin errors++; $display("FAIL lbu3_data got=%h exp=00000080", wb_data); end
    drive(1, 1, 2'b01, 3'b000, 32'd1, 32'h80FF_7F01, 5'd4);
    tick();
    checks++; if (wb_data !== 32'h0000_007F) begin errors++; $display("FAIL lb1_data got=%h exp=0000007f", wb_data); end
    drive(1, 1, 2'b01, 3'b000, 32'd2, 32'h80FF_7F01, 5'd4);
    tick();
    checks++; if (wb_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL lb2_data got=%h exp=ffffffff", wb_data); end
  endtask

  task automatic test_half_and_misalign();
    drive(1, 1, 2'b01, 3'b001, 32'd2, 32'h8001_0000, 5'd3);
    tick();
    checks++; if (wb_data !== 32'hFFFF_8001) begin errors++; $display("FAIL lh2_data got=%h exp=ffff8001", wb_data); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL lh2_err got=%b exp=0", misalign_err); end
    checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL lh2_we got=%b exp=1", wb_we); end
    drive(1, 1, 2'b01, 3'b101, 32'd2, 32'h8001_0000, 5'd3);
    tick();
    checks++; if (wb_data !== 32'h0000_8001) begin errors++; $display("FAIL lhu2_data got=%h exp=00008001", wb_data); end
    drive(1, 1, 2'b01, 3'b010, 32'd1, 32'h1234_5678, 5'd3);
    tick();
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL lw1_err got=%b exp=1", misalign_err); end
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL lw1_we got=%b exp=0", wb_we); end
    checks++; if (wb_data !== 32'h1234_5678) begin errors++; $display("FAIL lw1_data got=%h exp=12345678", wb_data); end
    drive(1, 1, 2'b01, 3'b001, 32'd1, 32'h1234_D678, 5'd3);
    tick();
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL lh1_err got=%b exp=1", misalign_err); end
    checks++; if (wb_data !== 32'hFFFF_D678) begin errors++; $display("FAIL lh1_data got=%h exp=ffffd678", wb_data); end
    drive(1, 1, 2'b01, 3'b011, 32'd1, 32'h1234_5678, 5'd3);
    tick();
    checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL undef_data got=%h exp=0", wb_data); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL undef_err got=%b exp=0", misalign_err); end
    drive(1, 1, 2'b00, 3'b010, 32'h0000_0101, 32'h1234_5678, 5'd3);
    tick();
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL alu_noerr got=%b exp=0", misalign_err); end
    checks++; if (wb_data !== 32'h0000_0101) begin errors++; $display("FAIL alu_data got=%h exp=00000101", wb_data); end
    imm = 32'hABCD_E000;
    drive(1, 1, 2'b11, 3'b010, 32'd1, 32'h0, 5'd3);
    tick();
    checks++; if (wb_data !== 32'hABCD_E000) begin errors++; $display("FAIL imm_data got=%h exp=abcde000", wb_data); end
    checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL imm_we got=%b exp=1", wb_we); end
  endtask

  task automatic test_stall_flush();
    drive(1, 1, 2'b00, 3'b000, 32'hA5A5_A5A5, 32'h0, 5'd7);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(i[0], 0, 2'b10, 3'b000, 32'h1111_0000 + i, 32'h0, 5'd9);
      pc_plus4 = 32'h2222_2222;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got=%b exp=0", i, in_ready); end
      tick();
      checks++; if (wb_rd !== 5'd7) begin errors++; $display("FAIL stall_rd[%0d] got=%0d exp=7", i, wb_rd); end
      checks++; if (wb_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL stall_data[%0d] got=%h exp=a5a5a5a5", i, wb_data); end
      checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b1) begin errors++; $display("FAIL stall_vwe[%0d] got=%b%b exp=11", i, wb_valid, wb_we); end
    end
    flush = 1'b1;
    drive(1, 1, 2'b00, 3'b000, 32'h0, 32'h0, 5'd9);
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", wb_valid); end
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL flush_we got=%b exp=0", wb_we); end
    stall = 1'b0; flush = 1'b0;
    drive(1, 1, 2'b01, 3'b010, 32'd2, 32'h0, 5'd9);
    tick();
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL preflush_err got=%b exp=1", misalign_err); end
    flush = 1'b1;
    tick();
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL flush_err got=%b exp=0", misalign_err); end
    flush = 1'b0;
  endtask

  task automatic test_x0_and_bubble();
    pc_plus4 = 32'h0000_0104;
    drive(1, 1, 2'b10, 3'b000, 32'h0, 32'h0, 5'd0);
    tick();
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL x0_valid got=%b exp=1", wb_valid); end
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL x0_we got=%b exp=0", wb_we); end
    checks++; if (wb_data !== 32'h0000_0104) begin errors++; $display("FAIL x0_data got=%h exp=00000104", wb_data); end
    drive(0, 1, 2'b00, 3'b000, 32'h55, 32'h0, 5'd6);
    tick();
    checks++; if (wb_valid !== 1'b0 || wb_we !== 1'b0) begin errors++; $display("FAIL bubble_vwe got=%b%b exp=00", wb_valid, wb_we); end
  endtask

  task automatic test_async_reset();
    drive(1, 1, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0, 5'd12);
    tick();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pre_arst got=%b/%h exp=1/deadbeef", wb_valid, wb_data); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", wb_valid); end
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL arst_we got=%b exp=0", wb_we); end
    checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL arst_data got=%h exp=0", wb_data); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL arst_rd got=%0d exp=0", wb_rd); end
    rst_n = 1'b1;
    tick();
    checks++; if (wb_data !== 32'hDEAD_BEEF || wb_valid !== 1'b1) begin errors++; $display("FAIL post_arst got=%b/%h exp=1/deadbeef", wb_valid, wb_data); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_byte_load();
    test_half_and_misalign();
    test_stall_flush();
    test_x0_and_bubble();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
